// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared types and widths for the mem_responder memory slice.
// Revision 1.0
// ============================================================================
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// mem_responder_if : controller-to-memory strobe/response bundle.
// Revision 1.0
// ============================================================================
interface mem_responder_if;
    import mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : single-port synchronous word storage with registered read data.
// Revision 1.0
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[idx];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : handshaked unified memory with WAIT_CYCLES wait states.
// Option MEM_MISALIGN_TRAP_EN: misaligned accesses error out. Revision 1.0
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    localparam int               IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0]      BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
    localparam bit               ZERO_WAIT  = (WAIT_CYCLES == 0);

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_rd;
    logic                r_wr;
    logic                r_err;
    logic                r_rd_zero;

    logic                w_start;
    logic                w_enter_resp;
    logic [WORD_W-1:0]   w_acc_addr;
    logic [WORD_W-1:0]   w_acc_wdata;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic                w_oor;
    logic                w_misalign;
    logic                w_err;
    logic                w_we;
    logic                w_re;
    logic [IDX_W-1:0]    w_idx;
    logic [WORD_W-1:0]   w_arr_rdata;
    logic                w_ready;
    logic                w_busy;

    assign w_start      = (r_state == IDLE) && (bus.mem_read || bus.mem_write);
    // Gated by rst_n so a zero-wait write cannot slip into the array during reset.
    assign w_enter_resp = rst_n && (((r_state == WAIT) && (r_cnt == '0)) ||
                                    (ZERO_WAIT && w_start));

    // Zero-wait accesses complete on the capture edge, so they use the live inputs.
    assign w_acc_addr  = (r_state == IDLE) ? bus.addr      : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? bus.wdata     : r_wdata;
    assign w_acc_rd    = (r_state == IDLE) ? bus.mem_read  : r_rd;
    assign w_acc_wr    = (r_state == IDLE) ? bus.mem_write : r_wr;

    assign w_oor = ({32'd0, w_acc_addr} >= BYTE_LIMIT);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_acc_addr[1:0] != 2'b00);
`else
    logic w_unused_lsb;
    assign w_misalign   = 1'b0;
    assign w_unused_lsb = ^w_acc_addr[1:0];
`endif

    assign w_err = (w_acc_rd && w_acc_wr) || w_oor || w_misalign;
    assign w_we  = w_enter_resp && w_acc_wr && !w_err;
    assign w_re  = w_enter_resp && w_acc_rd && !w_err;
    assign w_idx = w_acc_addr[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = ZERO_WAIT ? RESP : WAIT;
            WAIT:    if (r_cnt == '0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            IDLE:    ;
            WAIT:    w_busy = 1'b1;
            RESP: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= WAIT_LOAD;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_rd    <= bus.mem_read;
            r_wr    <= bus.mem_write;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WAIT_W'(1);
        end
    end

    // r_rd_zero masks the array output after an errored read; a conflicting
    // read+write leaves both it and the array output untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_rd_zero <= 1'b0;
        end else begin
            r_err <= w_enter_resp && w_err;
            if (w_enter_resp && w_acc_rd && !w_acc_wr) begin
                r_rd_zero <= w_oor || w_misalign;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .re    (w_re),
        .idx   (w_idx),
        .wdata (w_acc_wdata),
        .rdata (w_arr_rdata)
    );

    assign bus.rdata = r_rd_zero ? '0 : w_arr_rdata;
    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : directed plus random accesses against a word-array model.
// Revision 1.0
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    bit   trap_en;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_rdata;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; caller is positioned at a negedge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag, output int rc);
        bit          in_range;
        bit          mis;
        bit          exp_err;
        bit          seen;
        bit          busy_ok;
        bit          err_ok;
        int          lat;
        logic [31:0] got_rdata;
        logic        got_err;

        in_range = (a < 32'(DEPTH * 4));
        mis      = trap_en && (a[1:0] != 2'b00);
        exp_err  = (rd && wr) || !in_range || mis;

        if (!exp_err) begin
            if (wr) model[int'(a >> 2)] = d;
            else    exp_rdata = model[int'(a >> 2)];
        end else if (rd && !wr) begin
            exp_rdata = 32'd0;
        end

        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        lat = 0; seen = 0; busy_ok = 1; err_ok = 1; rc = 0;
        got_rdata = '0; got_err = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.ready === 1'b1) begin
                seen      = 1;
                got_rdata = bus.rdata;
                got_err   = bus.err;
                rc        = cyc;
            end else if (bus.err !== 1'b0) begin
                err_ok = 0;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        check(32'(seen),     32'd1,            {tag, ".ready_seen"});
        check(32'(lat),      32'(W + 2),       {tag, ".latency"});
        check(32'(busy_ok),  32'd1,            {tag, ".busy_held"});
        check(32'(err_ok),   32'd1,            {tag, ".err_only_with_ready"});
        check(32'(got_err),  32'(exp_err),     {tag, ".err"});
        check(got_rdata,     exp_rdata,        {tag, ".rdata"});
        @(negedge clk);
        check(32'(bus.ready), 32'd0,           {tag, ".ready_one_cycle"});
        check(32'(bus.busy),  32'd0,           {tag, ".busy_clear"});
    endtask

    initial begin
        int          rc1;
        int          rc2;
        int          kind;
        bit          seen;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] old2;

        checks = 0;
        errors = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        exp_rdata     = 32'd0;
        rst_n         = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        repeat (3) @(negedge clk);
        check(bus.rdata,         32'd0, "reset.rdata");
        check(32'(bus.ready),    32'd0, "reset.ready");
        check(32'(bus.busy),     32'd0, "reset.busy");
        check(32'(bus.err),      32'd0, "reset.err");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 1'b1, 32'(i * 4), $urandom, "fill", rc1);
        end

        access(1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, "preload3", rc1);
        access(1'b1, 1'b0, 32'h0000_000C, 32'h0,         "basic_read", rc1);

        access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, "wr10", rc1);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0,         "rd10", rc2);
        check(32'((rc2 - rc1) >= (W + 2)), 32'd1, "ready_spacing");

        access(1'b1, 1'b0, 32'h0000_0400, 32'h0,         "oor_read", rc1);
        access(1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, "oor_write", rc1);

        access(1'b1, 1'b0, 32'h0000_000C, 32'h0,         "reread3", rc1);
        access(1'b1, 1'b1, 32'h0000_0014, 32'hAAAA_5555, "both_strobes", rc1);

        access(1'b1, 1'b0, 32'h0000_0005, 32'h0,         "misaligned_read", rc1);

        // Reset pulse in the middle of a write's wait states.
        old2          = model[2];
        bus.mem_write = 1'b1;
        bus.addr      = 32'h0000_0008;
        bus.wdata     = ~old2;
        repeat (2) @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        check(bus.rdata,      32'd0, "rst_mid.rdata");
        check(32'(bus.ready), 32'd0, "rst_mid.ready");
        check(32'(bus.busy),  32'd0, "rst_mid.busy");
        check(32'(bus.err),   32'd0, "rst_mid.err");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exp_rdata = 32'd0;
        seen      = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen = 1;
        end
        check(32'(seen), 32'd0, "rst_mid.no_ready");
        access(1'b1, 1'b0, 32'h0000_0008, 32'h0, "rst_mid.word2", rc1);
        check(exp_rdata, old2, "rst_mid.word2_kept");

        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            rd   = $urandom_range(0, 1) == 1;
            wr   = !rd;
            if (kind <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (kind == 7) a = $urandom | 32'h0000_0400;
            else if (kind == 8) a = (32'($urandom_range(0, DEPTH - 1)) << 2) |
                                    32'($urandom_range(1, 3));
            else begin
                a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
                rd = 1'b1;
                wr = 1'b1;
            end
            access(rd, wr, a, $urandom, "random", rc1);
        end

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 1'b0, 32'(i * 4), 32'h0, "readback", rc1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
